// File: rtl/cpu_cluster_pkg.sv
// Shared defaults and types for the cpu_cluster fetch path.
// The modules derive their own widths from their parameters. These typedefs match the default configuration.
package cpu_cluster_pkg;

    localparam int N_CPUS_DEF  = 3;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 2;
    localparam int ID_W_DEF    = (N_CPUS_DEF > 1) ? $clog2(N_CPUS_DEF) : 1;

    typedef logic [ID_W_DEF-1:0] cpu_id_t;

    typedef struct packed {
        logic    valid;
        cpu_id_t id;
    } id_pipe_entry_t;

endpackage

// File: rtl/instr_mem_arbiter_rr_arbiter.sv
// Round-robin winner select over eligible requesters.
// Owns the rotating priority pointer, which always holds the last winner.
module rr_arbiter
    import cpu_cluster_pkg::*;
#(
    parameter int N_CPUS = N_CPUS_DEF,
    parameter int ID_W   = (N_CPUS > 1) ? $clog2(N_CPUS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CPUS-1:0] i_eligible,
    output logic [N_CPUS-1:0] o_gnt_onehot,
    output logic [ID_W-1:0]   o_gnt_id
);

    logic [ID_W-1:0]   r_rr_ptr;
    logic [N_CPUS-1:0] w_rot;
    logic [N_CPUS-1:0] w_gnt_onehot;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_found;
    int                w_sum;

    // Rotate the request vector so that bit 0 is the CPU just after the last winner.
    always_comb begin
        w_rot        = N_CPUS'({i_eligible, i_eligible} >> (int'(r_rr_ptr) + 1));
        w_found      = 1'b0;
        w_sum        = 0;
        w_gnt_onehot = '0;
        for (int j = 0; j < N_CPUS; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = int'(r_rr_ptr) + 1 + j;
            end
        end
        if (w_sum >= N_CPUS) w_sum = w_sum - N_CPUS;
        w_gnt_id = ID_W'(w_sum);
        for (int i = 0; i < N_CPUS; i++) begin
            w_gnt_onehot[i] = w_found && (w_gnt_id == ID_W'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= ID_W'(N_CPUS - 1);
        end else if (w_found) begin
            r_rr_ptr <= w_gnt_id;
        end
    end

    assign o_gnt_onehot = w_gnt_onehot;
    assign o_gnt_id     = w_gnt_id;

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares one pipelined fixed-latency instruction ROM among N_CPUS fetch ports.
// An ID pipeline as deep as the ROM latency steers each result back to the CPU that issued it.
module instr_mem_arbiter
    import cpu_cluster_pkg::*;
#(
    parameter int N_CPUS  = N_CPUS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_CPUS-1:0]             i_cpu_req,
    input  logic [N_CPUS-1:0][ADDR_W-1:0] i_cpu_addr,
    output logic [N_CPUS-1:0]             o_cpu_gnt,
    output logic [N_CPUS-1:0]             o_cpu_rvalid,
    output logic [N_CPUS-1:0][DATA_W-1:0] o_cpu_rdata,
    output logic                          o_mem_req,
    output logic [ADDR_W-1:0]             o_mem_addr,
    input  logic [DATA_W-1:0]             i_mem_rdata
);

    localparam int ID_W = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } pipe_entry_t;

    logic [N_CPUS-1:0]             r_pending;
    logic [N_CPUS-1:0]             r_cpu_rvalid;
    logic [N_CPUS-1:0][DATA_W-1:0] r_cpu_rdata;
    pipe_entry_t                   r_id_pipe [MEM_LAT];

    logic [N_CPUS-1:0] w_eligible;
    logic [N_CPUS-1:0] w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic [N_CPUS-1:0] w_clr;
    logic [ADDR_W-1:0] w_mem_addr;
    pipe_entry_t       w_last;

    assign w_eligible = i_cpu_req & ~r_pending;
    assign w_last     = r_id_pipe[MEM_LAT-1];

    rr_arbiter #(
        .N_CPUS (N_CPUS),
        .ID_W   (ID_W)
    ) u_rr_arbiter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_eligible   (w_eligible),
        .o_gnt_onehot (w_gnt),
        .o_gnt_id     (w_gnt_id)
    );

    always_comb begin
        w_mem_addr = '0;
        w_clr      = '0;
        for (int i = 0; i < N_CPUS; i++) begin
            if (w_gnt[i]) w_mem_addr = i_cpu_addr[i];
            w_clr[i] = w_last.valid && (w_last.id == ID_W'(i));
        end
    end

    // A grant in the same cycle as that CPU's result re-arms its pending bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending    <= '0;
            r_cpu_rvalid <= '0;
            r_cpu_rdata  <= '0;
            for (int k = 0; k < MEM_LAT; k++) r_id_pipe[k] <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_clr) | w_gnt;
            r_cpu_rvalid <= w_clr;
            for (int i = 0; i < N_CPUS; i++) begin
                if (w_clr[i]) r_cpu_rdata[i] <= i_mem_rdata;
            end
            r_id_pipe[0] <= '{valid: |w_gnt, id: w_gnt_id};
            for (int k = 1; k < MEM_LAT; k++) r_id_pipe[k] <= r_id_pipe[k-1];
        end
    end

    assign o_cpu_gnt    = w_gnt;
    assign o_mem_req    = |w_gnt;
    assign o_mem_addr   = w_mem_addr;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed-vector bench for instr_mem_arbiter (3 CPUs, ROM latency 2).
// A model ROM returns {addr[15:0], 16'hA5A5} two cycles after the request.
module tb_instr_mem_arbiter;

    logic              clk;
    logic              rst;
    logic [2:0]        cpu_req;
    logic [2:0][31:0]  cpu_addr;
    logic [2:0]        cpu_gnt;
    logic [2:0]        cpu_rvalid;
    logic [2:0][31:0]  cpu_rdata;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       rom_s1;
    logic [31:0]       rom_s2;

    int n_vec  = 0;
    int n_miss = 0;

    instr_mem_arbiter #(
        .N_CPUS  (3),
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (cpu_req),
        .i_cpu_addr   (cpu_addr),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_s1 <= {mem_addr[15:0], 16'hA5A5};
        rom_s2 <= rom_s1;
    end
    assign mem_rdata = rom_s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [2:0] gnt_tbl [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] rv_tbl  [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100};

    initial begin
        rst      = 1'b1;
        cpu_req  = '0;
        cpu_addr = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_rvalid", 64'(cpu_rvalid), 64'h0);
        chk("rst_rdata0", 64'(cpu_rdata[0]), 64'h0);
        chk("rst_gnt", 64'(cpu_gnt), 64'h0);
        rst = 1'b0;

        // single requester CPU1
        cyc(); cpu_req = 3'b010; cpu_addr[1] = 32'h30; #1;
        chk("s1_gnt", 64'(cpu_gnt), 64'h2);
        chk("s1_memreq", 64'(mem_req), 64'h1);
        chk("s1_memaddr", 64'(mem_addr), 64'h30);
        cyc(); cpu_req = 3'b000; #1;
        chk("s1_rv_t1", 64'(cpu_rvalid), 64'h0);
        cyc(); #1;
        chk("s1_rv_t2", 64'(cpu_rvalid), 64'h0);
        cyc(); #1;
        chk("s1_rv_t3", 64'(cpu_rvalid), 64'h2);
        chk("s1_rdata1", 64'(cpu_rdata[1]), 64'h0030A5A5);
        cyc(); #1;
        chk("s1_rv_t4", 64'(cpu_rvalid), 64'h0);
        chk("s1_rdata1_hold", 64'(cpu_rdata[1]), 64'h0030A5A5);

        // bring rrPtr to 0 with a lone CPU0 fetch
        cyc(); cpu_req = 3'b001; cpu_addr[0] = 32'h40; #1;
        chk("p0_gnt", 64'(cpu_gnt), 64'h1);
        cyc(); cpu_req = 3'b000;
        cyc();
        cyc(); #1;
        chk("p0_rv", 64'(cpu_rvalid), 64'h1);
        chk("p0_rdata0", 64'(cpu_rdata[0]), 64'h0040A5A5);

        // CPU0 and CPU2 with rrPtr=0: CPU2 first, then wrap to CPU0
        cyc(); cpu_req = 3'b101; cpu_addr[0] = 32'h50; cpu_addr[2] = 32'h60; #1;
        chk("s3_gnt_a", 64'(cpu_gnt), 64'h4);
        chk("s3_addr_a", 64'(mem_addr), 64'h60);
        cyc(); cpu_req = 3'b001; #1;
        chk("s3_gnt_b", 64'(cpu_gnt), 64'h1);
        chk("s3_addr_b", 64'(mem_addr), 64'h50);
        cyc(); cpu_req = 3'b000; #1;
        chk("s3_rv_t2", 64'(cpu_rvalid), 64'h0);
        cyc(); #1;
        chk("s3_rv_c2", 64'(cpu_rvalid), 64'h4);
        chk("s3_rdata2", 64'(cpu_rdata[2]), 64'h0060A5A5);
        cyc(); #1;
        chk("s3_rv_c0", 64'(cpu_rvalid), 64'h1);
        chk("s3_rdata0", 64'(cpu_rdata[0]), 64'h0050A5A5);

        // CPU0 holds its request while pending
        cyc(); cpu_req = 3'b001; cpu_addr[0] = 32'h70; #1;
        chk("s4_gnt_t0", 64'(cpu_gnt), 64'h1);
        cyc(); #1;
        chk("s4_gnt_t1", 64'(cpu_gnt), 64'h0);
        chk("s4_pend_t1", 64'(dut.r_pending), 64'h1);
        cyc(); #1;
        chk("s4_gnt_t2", 64'(cpu_gnt), 64'h0);
        cyc(); #1;
        chk("s4_rv_t3", 64'(cpu_rvalid), 64'h1);
        chk("s4_regnt_t3", 64'(cpu_gnt), 64'h1);
        chk("s4_rdata0", 64'(cpu_rdata[0]), 64'h0070A5A5);
        cyc(); cpu_req = 3'b000; #1;
        chk("s4_pend_t4", 64'(dut.r_pending), 64'h1);
        repeat (4) cyc();

        // fresh reset, then all three request continuously
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; cpu_req = 3'b111;
        cpu_addr[0] = 32'h100; cpu_addr[1] = 32'h204; cpu_addr[2] = 32'h308;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("s2_gnt_%0d", k), 64'(cpu_gnt), 64'(gnt_tbl[k]));
            chk($sformatf("s2_rv_%0d", k), 64'(cpu_rvalid), 64'(rv_tbl[k]));
            if (k == 3) chk("s2_rdata0", 64'(cpu_rdata[0]), 64'h0100A5A5);
            if (k == 5) chk("s2_rdata2", 64'(cpu_rdata[2]), 64'h0308A5A5);
            cyc();
        end

        // reset with fetches in flight
        rst = 1'b1; cpu_req = 3'b000;
        cyc(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("s5_rv_%0d", k), 64'(cpu_rvalid), 64'h0);
            if (k == 0) begin
                chk("s5_rdata0", 64'(cpu_rdata[0]), 64'h0);
                chk("s5_rdata1", 64'(cpu_rdata[1]), 64'h0);
                chk("s5_rdata2", 64'(cpu_rdata[2]), 64'h0);
            end
            cyc();
        end
        cpu_req = 3'b111; #1;
        chk("s5_first_gnt", 64'(cpu_gnt), 64'h1);
        cyc(); cpu_req = 3'b000;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
